// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: defaults, state encoding, port ids.
package mem_port_arbiter_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } arb_state_e;

    // Port ids double as bit positions in the request/grant vectors.
    localparam logic PORT_F = 1'b0;
    localparam logic PORT_D = 1'b1;

    // Load value for the WAIT down-counter: terminal count 0 marks the last WAIT cycle.
    function automatic logic [2:0] wait_init(input int rd_lat);
        return 3'(rd_lat - 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_arb2_pick.sv
// Two-way combinational picker: one-hot grant from {D, F} requests.
module arb2_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       rr_en,
    output logic [1:0] gnt
);

    // Single requester always wins; a tie goes to the port not granted last (RR) or to D.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (rr_en && (last == PORT_D)) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch (F) and data (D) accesses onto the single-port main memory.
//
//  state  | meaning
//  IDLE   | waiting for a request; winner's address/we/wdata latched on exit
//  ACCESS | single mem_en cycle, grant pulse to the winner
//  WAIT   | reads only: RD_LAT cycles, read data captured in the last one
//  DONE   | done pulse to the winner
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 1,
    parameter int RR_EN  = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_done,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic       RR_BIT    = (RR_EN != 0);
    localparam logic [2:0] CNT_START = wait_init(RD_LAT);

    arb_state_e        state_q, state_d;
    logic              last_gnt_q, last_gnt_d;
    logic              win_q, win_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic [1:0]        pick_gnt;

    arb2_pick u_pick (
        .req   ({d_req, f_req}),
        .last  (last_gnt_q),
        .rr_en (RR_BIT),
        .gnt   (pick_gnt)
    );

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            last_gnt_q <= PORT_D;
            win_q      <= PORT_F;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            f_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            win_q      <= win_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            f_rdata_q  <= f_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // Next state: requests are only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (|pick_gnt) state_d = ST_ACCESS;
            ST_ACCESS: state_d = we_q ? ST_DONE : ST_WAIT;
            ST_WAIT:   if (cnt_q == 3'd0) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Request latch, latency counter and read-data capture into the winner's register only.
    always_comb begin
        last_gnt_d = last_gnt_q;
        win_d      = win_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        f_rdata_d  = f_rdata_q;
        d_rdata_d  = d_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (|pick_gnt) begin
                    win_d      = pick_gnt[1];
                    last_gnt_d = pick_gnt[1];
                    if (pick_gnt[1]) begin
                        we_d    = d_we;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                    end else begin
                        we_d    = 1'b0;
                        addr_d  = f_addr;
                        wdata_d = '0;
                    end
                end
            end
            ST_ACCESS: cnt_d = CNT_START;
            ST_WAIT: begin
                if (cnt_q == 3'd0) begin
                    if (win_q == PORT_D) d_rdata_d = mem_rdata;
                    else                 f_rdata_d = mem_rdata;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: ;
        endcase
    end

    // Moore outputs; the memory bus is forced to zero outside the ACCESS cycle.
    always_comb begin
        mem_en    = (state_q == ST_ACCESS);
        mem_we    = mem_en & we_q;
        mem_addr  = mem_en ? addr_q  : '0;
        mem_wdata = mem_en ? wdata_q : '0;
        f_gnt     = mem_en & (win_q == PORT_F);
        d_gnt     = mem_en & (win_q == PORT_D);
        f_done    = (state_q == ST_DONE) & (win_q == PORT_F);
        d_done    = (state_q == ST_DONE) & (win_q == PORT_D);
        busy      = (state_q != ST_IDLE);
        f_rdata   = f_rdata_q;
        d_rdata   = d_rdata_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (RD_LAT=1 RR, RD_LAT=4 RR, RD_LAT=1 fixed priority)
// share one stimulus; only the instance under test is monitored.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        f_req, d_req, d_we;
    logic [11:0] f_addr, d_addr;
    logic [15:0] d_wdata;

    logic [2:0]  f_gnt_a, f_done_a, d_gnt_a, d_done_a, mem_en_a, mem_we_a, busy_a;
    logic [11:0] mem_addr_a  [3];
    logic [15:0] mem_wdata_a [3];
    logic [15:0] mem_rdata_a [3];
    logic [15:0] f_rdata_a   [3];
    logic [15:0] d_rdata_a   [3];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mon_inst = 0;
    bit mon_en = 1'b0;
    logic [15:0] exp_f, exp_d;

    typedef struct {
        logic        port;
        int          cyc;
        logic [15:0] f_rd;
        logic [15:0] d_rd;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 1) ? 4 : 1;
        localparam int RR  = (g == 2) ? 0 : 1;
        logic [15:0] mem  [4096];
        logic [15:0] pipe [8];

        initial begin
            for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
            mem[12'h010] = 16'h1234;
            mem[12'h030] = 16'h5A5A;
        end

        // Memory model: read data travels down a pipe so it appears LAT cycles after mem_en.
        always @(posedge clk) begin
            if (mem_en_a[g] && mem_we_a[g]) mem[mem_addr_a[g]] <= mem_wdata_a[g];
            pipe[0] <= (mem_en_a[g] && !mem_we_a[g]) ? mem[mem_addr_a[g]] : 16'hDEAD;
            for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
        end
        assign mem_rdata_a[g] = pipe[LAT-1];

        mem_port_arbiter #(.ADDR_W(12), .DATA_W(16), .RD_LAT(LAT), .RR_EN(RR)) u_dut (
            .clk       (clk),
            .reset_n   (reset_n),
            .f_req     (f_req),
            .f_addr    (f_addr),
            .f_gnt     (f_gnt_a[g]),
            .f_done    (f_done_a[g]),
            .f_rdata   (f_rdata_a[g]),
            .d_req     (d_req),
            .d_we      (d_we),
            .d_addr    (d_addr),
            .d_wdata   (d_wdata),
            .d_gnt     (d_gnt_a[g]),
            .d_done    (d_done_a[g]),
            .d_rdata   (d_rdata_a[g]),
            .mem_en    (mem_en_a[g]),
            .mem_we    (mem_we_a[g]),
            .mem_addr  (mem_addr_a[g]),
            .mem_wdata (mem_wdata_a[g]),
            .mem_rdata (mem_rdata_a[g]),
            .busy      (busy_a[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic port, input int lat);
        exp_t e;
        e.port = port;
        e.cyc  = cyc + lat;
        e.f_rd = exp_f;
        e.d_rd = exp_d;
        sb.push_back(e);
    endtask

    task automatic wait_sb(input int max_cyc);
        int n = 0;
        while (sb.size() != 0 && n < max_cyc) begin
            step();
            n++;
        end
        step();
        chk("sb_drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset(input int inst);
        reset_n = 1'b0;
        f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        f_addr = '0; d_addr = '0; d_wdata = '0;
        step();
        step();
        reset_n  = 1'b1;
        mon_inst = inst;
        mon_en   = 1'b1;
        exp_f    = '0;
        exp_d    = '0;
        chk("rst_busy",    32'(busy_a[inst]),    32'd0);
        chk("rst_mem_en",  32'(mem_en_a[inst]),  32'd0);
        chk("rst_f_rdata", 32'(f_rdata_a[inst]), 32'd0);
        chk("rst_d_rdata", 32'(d_rdata_a[inst]), 32'd0);
    endtask

    // Monitor: pops the scoreboard on every done pulse, plus bus-idle and exclusivity rules.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("f_d_exclusive",
                32'((f_gnt_a[mon_inst] | f_done_a[mon_inst]) & (d_gnt_a[mon_inst] | d_done_a[mon_inst])),
                32'd0);
            if (!mem_en_a[mon_inst])
                chk("idle_bus_zero",
                    {3'b0, mem_we_a[mon_inst], mem_addr_a[mon_inst], mem_wdata_a[mon_inst]}, 32'd0);
            if (f_done_a[mon_inst] || d_done_a[mon_inst]) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL unexpected_done: f_done %b d_done %b with nothing expected (cycle %0d)",
                           f_done_a[mon_inst], d_done_a[mon_inst], cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("done_port",  32'(d_done_a[mon_inst]),  32'(e.port));
                    chk("done_cycle", 32'(cyc),                 32'(e.cyc));
                    chk("f_rdata",    32'(f_rdata_a[mon_inst]), 32'(e.f_rd));
                    chk("d_rdata",    32'(d_rdata_a[mon_inst]), 32'(e.d_rd));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        f_addr = '0; d_addr = '0; d_wdata = '0;
        exp_f = '0; exp_d = '0;

        // Single F read.
        do_reset(0);
        f_req = 1'b1; f_addr = 12'h010;
        exp_f = 16'h1234;
        push_exp(1'b0, 3);
        step();
        chk("t1_f_gnt",    32'(f_gnt_a[0]),    32'd1);
        chk("t1_d_gnt",    32'(d_gnt_a[0]),    32'd0);
        chk("t1_mem_en",   32'(mem_en_a[0]),   32'd1);
        chk("t1_mem_we",   32'(mem_we_a[0]),   32'd0);
        chk("t1_mem_addr", 32'(mem_addr_a[0]), 32'h010);
        f_req = 1'b0;
        wait_sb(10);
        chk("t1_f_rdata_hold", 32'(f_rdata_a[0]), 32'h1234);

        // D write then read-back.
        d_req = 1'b1; d_we = 1'b1; d_addr = 12'h020; d_wdata = 16'hBEEF;
        push_exp(1'b1, 2);
        step();
        chk("t2_d_gnt",     32'(d_gnt_a[0]),     32'd1);
        chk("t2_mem_we",    32'(mem_we_a[0]),    32'd1);
        chk("t2_mem_addr",  32'(mem_addr_a[0]),  32'h020);
        chk("t2_mem_wdata", 32'(mem_wdata_a[0]), 32'hBEEF);
        d_req = 1'b0; d_we = 1'b0; d_wdata = '0;
        wait_sb(10);
        d_req = 1'b1; d_addr = 12'h020;
        exp_d = 16'hBEEF;
        push_exp(1'b1, 3);
        step();
        chk("t2_rd_gnt",    32'(d_gnt_a[0]),  32'd1);
        chk("t2_rd_mem_we", 32'(mem_we_a[0]), 32'd0);
        d_req = 1'b0;
        wait_sb(10);

        // Both held, round-robin: F, D, F, D.
        do_reset(0);
        f_addr = 12'h010; d_addr = 12'h030; f_req = 1'b1; d_req = 1'b1;
        exp_f = 16'h1234;
        push_exp(1'b0, 3);
        exp_d = 16'h5A5A;
        push_exp(1'b1, 7);
        push_exp(1'b0, 11);
        push_exp(1'b1, 15);
        repeat (15) step();
        f_req = 1'b0; d_req = 1'b0;
        wait_sb(10);

        // Both held, fixed priority: D only.
        do_reset(2);
        f_addr = 12'h010; d_addr = 12'h030; f_req = 1'b1; d_req = 1'b1;
        exp_d = 16'h5A5A;
        push_exp(1'b1, 3);
        push_exp(1'b1, 7);
        push_exp(1'b1, 11);
        repeat (11) step();
        f_req = 1'b0; d_req = 1'b0;
        wait_sb(10);
        chk("t3_fp_f_rdata", 32'(f_rdata_a[2]), 32'd0);

        // RD_LAT=4: done six cycles after request, f_rdata untouched until then.
        do_reset(1);
        f_req = 1'b1; f_addr = 12'h010;
        exp_f = 16'h1234;
        push_exp(1'b0, 6);
        step();
        f_req = 1'b0;
        repeat (4) begin
            step();
            chk("t4_f_rdata_hold", 32'(f_rdata_a[1]), 32'd0);
        end
        wait_sb(10);

        // Reset in the WAIT of a D read: no done, outputs cleared, next tie goes to F.
        do_reset(0);
        d_req = 1'b1; d_we = 1'b0; d_addr = 12'h010;
        step();
        chk("t5_d_gnt", 32'(d_gnt_a[0]), 32'd1);
        d_req = 1'b0;
        step();
        chk("t5_busy_wait", 32'(busy_a[0]), 32'd1);
        reset_n = 1'b0;
        step();
        chk("t5_busy",    32'(busy_a[0]),    32'd0);
        chk("t5_mem_en",  32'(mem_en_a[0]),  32'd0);
        chk("t5_d_done",  32'(d_done_a[0]),  32'd0);
        chk("t5_d_rdata", 32'(d_rdata_a[0]), 32'd0);
        reset_n = 1'b1;
        f_req = 1'b1; d_req = 1'b1; f_addr = 12'h010; d_addr = 12'h030;
        exp_f = 16'h1234;
        push_exp(1'b0, 3);
        step();
        chk("t5_tie_f_gnt", 32'(f_gnt_a[0]), 32'd1);
        chk("t5_tie_d_gnt", 32'(d_gnt_a[0]), 32'd0);
        f_req = 1'b0; d_req = 1'b0;
        wait_sb(10);

        // F last granted, then reset: a tie must still go to F.
        do_reset(0);
        f_req = 1'b1; f_addr = 12'h010;
        exp_f = 16'h1234;
        push_exp(1'b0, 3);
        step();
        f_req = 1'b0;
        wait_sb(10);
        do_reset(0);
        f_req = 1'b1; d_req = 1'b1; f_addr = 12'h010; d_addr = 12'h030;
        exp_f = 16'h1234;
        push_exp(1'b0, 3);
        step();
        chk("t7_tie_f_gnt", 32'(f_gnt_a[0]), 32'd1);
        f_req = 1'b0; d_req = 1'b0;
        wait_sb(10);

        // D raised during F's WAIT: ignored until IDLE, then served.
        f_req = 1'b1; f_addr = 12'h010;
        push_exp(1'b0, 3);
        step();
        chk("t6_f_gnt", 32'(f_gnt_a[0]), 32'd1);
        f_req = 1'b0;
        step();
        chk("t6_busy_wait", 32'(busy_a[0]), 32'd1);
        d_req = 1'b1; d_we = 1'b0; d_addr = 12'h030;
        exp_d = 16'h5A5A;
        push_exp(1'b1, 5);
        step();
        chk("t6_busy_done", 32'(busy_a[0]),  32'd1);
        chk("t6_no_d_gnt",  32'(d_gnt_a[0]), 32'd0);
        step();
        chk("t6_idle_busy", 32'(busy_a[0]),  32'd0);
        chk("t6_idle_gnt",  32'(d_gnt_a[0]), 32'd0);
        step();
        chk("t6_d_gnt",    32'(d_gnt_a[0]), 32'd1);
        chk("t6_busy_acc", 32'(busy_a[0]),  32'd1);
        d_req = 1'b0;
        wait_sb(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
